decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Instruction decode stage that sits directly upstream of the ALU.
- Accepts 32-bit MIPS-style R-type and ADDI instructions through a valid/ready handshake and reads operands from an internal 32x32 register file.
- Registers the ALU inputs (a, b, func, alusrc) plus the destination index into a single pipeline register.
- Also owns the register-file write port used by writeback.

Parameters:
- DATA_W, 32, operand/register width
- REG_CNT, 32, number of architectural registers (index width = $clog2(REG_CNT))

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  instruction present
- in_ready  out  1  stage can accept instruction
- in_instr  in  32  instruction word
- flush  in  1  discard the held pipeline entry
- out_valid  out  1  ALU inputs valid
- out_ready  in  1  downstream accepts
- out_a  out  DATA_W  ALU operand a
- out_b  out  DATA_W  ALU operand b
- out_func  out  6  ALU function code
- out_alusrc  out  1  ALU enable (1 = supported op)
- out_rd  out  5  destination register index
- out_illegal  out  1  unsupported opcode/funct
- wb_en  in  1  register write enable
- wb_addr  in  5  write index
- wb_data  in  DATA_W  write data

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_a=0, out_b=0, out_func=0, out_alusrc=0, out_rd=0, out_illegal=0.
  - All registers cleared to 0.
  - Deassertion is used synchronously (2-flop synchroniser external).
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Accept on the clk edge where in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - out_* held stable while out_valid && !out_ready.
- Latency: 1 cycle from accept to out_valid. Full throughput of one instruction per cycle when out_ready stays high.
- Field decode: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0].
- R-type (op=000000):
  - funct 100000/100010/100100/100101: a=R[rs], b=R[rt], func=funct, rd=rd, alusrc=1.
  - funct 000000/000010 (shifts): a=R[rt], b=zero-extended shamt, func=funct, rd=rd, alusrc=1.
- ADDI (op=001000): a=R[rs], b=sign-extended imm[15:0], func=100000, rd=rt, alusrc=1.
- Any other op/funct:
  - out_illegal=1, alusrc=0, func=funct, rd=0, a=b=0.
  - out_valid still asserts, so the bubble flows through.
- Register file:
  - R[0] reads 0 always; writes to index 0 are ignored.
  - Write occurs on the clk edge when wb_en=1.
  - Reads are combinational from in_instr fields, sampled at accept.
- Flush:
  - Synchronous; clears out_valid next edge and has priority over a hold.
  - Flush with a simultaneous accept: the incoming instruction is loaded (flush kills only the old entry).
- Reset mid-operation: the held entry is lost and out_valid drops immediately (async).

Optional Feature:
- Macro: WB_BYPASS_EN
- Defined: if wb_en && wb_addr!=0 && wb_addr equals rs or rt in the same cycle as accept, the operand takes wb_data (write-through bypass).
- Undefined: the operand takes the pre-write register value. The hazard is software/scheduler responsibility.
- Register-file contents after the edge are identical in both builds.

Decomposition:
- Shared package alu_pkg:
  - opcode constants OP_RTYPE=6'b000000, OP_ADDI=6'b001000.
  - funct constants F_ADD=100000, F_SUB=100010, F_AND=100100, F_OR=100101, F_SLL=000000, F_SRL=000010.
  - instruction field typedef.
- Sub-module reg_file: 2 async read ports, 1 sync write port, R[0] hardwired 0, async active-low reset; the optional bypass lives inside it.
- decode_stage instantiates reg_file and holds the decode logic and pipeline register.

Test Plan:
- Reset, write R1=5 and R2=3, send R-type add (rs=1, rt=2, rd=3, funct=100000) -> next cycle out_valid=1, a=5, b=3, func=100000, alusrc=1, rd=3.
- ADDI rs=1, rt=4, imm=16'hFFFF -> a=5, b=32'hFFFFFFFF, func=100000, rd=4.
- SLL with rt=2, shamt=4 -> a=3, b=4, func=000000. Op=6'b100011 -> out_illegal=1, alusrc=0.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable. Then out_ready=1 -> next instruction is accepted the same cycle.
- wb_en=1, wb_addr=1, wb_data=9 in the accept cycle of an add reading R1 -> a=9 with WB_BYPASS_EN, a=5 without. A write to R0 followed by a read of R0 -> 0.
- flush while out_valid && !out_ready -> out_valid=0 next cycle. Drop rst_n mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Brief    : Opcode/funct constants and instruction field layout shared by
//             the decode stage and the ALU.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;

    // MIPS-style field split; for I-type the low three fields form imm[15:0]
    typedef struct packed {
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        logic [4:0] shamt;
        logic [5:0] funct;
    } instr_t;

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
//  Module   : reg_file
//  Brief    : REG_CNT x DATA_W register file, two combinational read ports,
//             one synchronous write port, R[0] reads as zero.
//             Build option WB_BYPASS_EN: a read whose index matches the write
//             in the same cycle returns the write data (write-through).
//  Revision : 1.0 - initial release
// ============================================================================
module reg_file #(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32,
    parameter int AW      = $clog2(REG_CNT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [AW-1:0]     ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [AW-1:0]     rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] regs_q [REG_CNT];
    logic [DATA_W-1:0] regs_d [REG_CNT];
    logic              wr_live;

    // Index 0 is never written, so its storage stays at the reset value
    assign wr_live = wr_en && (wr_addr != '0);

    // Next-state of the array: only the addressed entry changes
    always_comb begin
        for (int i = 0; i < REG_CNT; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_live) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Storage, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports: R[0] forced to zero, optional same-cycle forwarding of the write
    always_comb begin
        ra_data = (ra_addr == '0) ? '0 : regs_q[ra_addr];
        rb_data = (rb_addr == '0) ? '0 : regs_q[rb_addr];
`ifdef WB_BYPASS_EN
        if (wr_live && (wr_addr == ra_addr)) begin
            ra_data = wr_data;
        end
        if (wr_live && (wr_addr == rb_addr)) begin
            rb_data = wr_data;
        end
`endif
    end

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : decode_stage
//  Brief    : Instruction decode ahead of the ALU. Decodes R-type
//             (add/sub/and/or/sll/srl) and ADDI, reads operands from the
//             internal register file and holds the ALU inputs in a single
//             valid/ready pipeline register. Owns the writeback port.
//             Build option WB_BYPASS_EN: writeback data forwarded to operands
//             read in the same cycle (see reg_file).
//  Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import alu_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_CNT = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [5:0]        out_func,
    output logic              out_alusrc,
    output logic [4:0]        out_rd,
    output logic              out_illegal,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data
);

    localparam int AW = $clog2(REG_CNT);

    instr_t            f;
    logic [15:0]       imm;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              accept;

    logic [DATA_W-1:0] dec_a;
    logic [DATA_W-1:0] dec_b;
    logic [5:0]        dec_func;
    logic              dec_alusrc;
    logic [4:0]        dec_rd;
    logic              dec_illegal;

    logic              valid_q,   valid_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic [5:0]        func_q,    func_d;
    logic              alusrc_q,  alusrc_d;
    logic [4:0]        rd_q,      rd_d;
    logic              illegal_q, illegal_d;

    assign f   = instr_t'(in_instr);
    assign imm = {f.rd, f.shamt, f.funct};

    reg_file #(
        .DATA_W  (DATA_W),
        .REG_CNT (REG_CNT),
        .AW      (AW)
    ) u_reg_file (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (f.rs[AW-1:0]),
        .ra_data (rs_data),
        .rb_addr (f.rt[AW-1:0]),
        .rb_data (rt_data),
        .wr_en   (wb_en),
        .wr_addr (wb_addr[AW-1:0]),
        .wr_data (wb_data)
    );

    // The slot can take a new instruction when empty or draining this cycle
    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Field decode; anything unrecognised becomes an illegal bubble with zeroed operands
    always_comb begin
        dec_a       = '0;
        dec_b       = '0;
        dec_func    = f.funct;
        dec_alusrc  = 1'b0;
        dec_rd      = '0;
        dec_illegal = 1'b1;
        case (f.op)
            OP_RTYPE: begin
                case (f.funct)
                    F_ADD, F_SUB, F_AND, F_OR: begin
                        dec_a       = rs_data;
                        dec_b       = rt_data;
                        dec_rd      = f.rd;
                        dec_alusrc  = 1'b1;
                        dec_illegal = 1'b0;
                    end
                    F_SLL, F_SRL: begin
                        dec_a       = rt_data;
                        dec_b       = {{(DATA_W-5){1'b0}}, f.shamt};
                        dec_rd      = f.rd;
                        dec_alusrc  = 1'b1;
                        dec_illegal = 1'b0;
                    end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                dec_a       = rs_data;
                dec_b       = {{(DATA_W-16){imm[15]}}, imm};
                dec_func    = F_ADD;
                dec_rd      = f.rt;
                dec_alusrc  = 1'b1;
                dec_illegal = 1'b0;
            end
            default: ;
        endcase
    end

    // Pipeline register next-state: load on accept, otherwise drop on transfer or flush, else hold
    always_comb begin
        valid_d   = valid_q;
        a_d       = a_q;
        b_d       = b_q;
        func_d    = func_q;
        alusrc_d  = alusrc_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        if (accept) begin
            // A flush in the same cycle only kills the old entry, so the new one still loads
            valid_d   = 1'b1;
            a_d       = dec_a;
            b_d       = dec_b;
            func_d    = dec_func;
            alusrc_d  = dec_alusrc;
            rd_d      = dec_rd;
            illegal_d = dec_illegal;
        end else if (flush || (valid_q && out_ready)) begin
            valid_d = 1'b0;
        end
    end

    // Pipeline register, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            func_q    <= '0;
            alusrc_q  <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            a_q       <= a_d;
            b_q       <= b_d;
            func_q    <= func_d;
            alusrc_q  <= alusrc_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_a       = a_q;
    assign out_b       = b_q;
    assign out_func    = func_q;
    assign out_alusrc  = alusrc_q;
    assign out_rd      = rd_q;
    assign out_illegal = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decode_stage
//  Brief    : Scoreboard bench for decode_stage. Directed instructions push
//             their hand-computed ALU inputs; a monitor pops and compares on
//             every output transfer. Honours WB_BYPASS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [5:0]  out_func;
    logic        out_alusrc;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    decode_stage #(
        .DATA_W  (32),
        .REG_CNT (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_func    (out_func),
        .out_alusrc  (out_alusrc),
        .out_rd      (out_rd),
        .out_illegal (out_illegal),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  func;
        logic        alusrc;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_got;
    exp_t mon_exp;
    int   n_run  = 0;
    int   n_fail = 0;

`ifdef WB_BYPASS_EN
    localparam logic [31:0] BYP_A = 32'd9;
`else
    localparam logic [31:0] BYP_A = 32'd5;
`endif

    function automatic exp_t mk(input logic [31:0] a, input logic [31:0] b,
                                input logic [5:0] func, input logic alusrc,
                                input logic [4:0] rd, input logic ill);
        exp_t e;
        e.a = a; e.b = b; e.func = func; e.alusrc = alusrc; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every output transfer must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_got = {out_a, out_b, out_func, out_alusrc, out_rd, out_illegal};
            n_run++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL xfer_unexpected: got a=%h b=%h func=%h alusrc=%b rd=%0d ill=%b with empty scoreboard",
                         mon_got.a, mon_got.b, mon_got.func, mon_got.alusrc, mon_got.rd, mon_got.ill);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    n_fail++;
                    $display("FAIL xfer: got a=%h b=%h func=%h alusrc=%b rd=%0d ill=%b expected a=%h b=%h func=%h alusrc=%b rd=%0d ill=%b",
                             mon_got.a, mon_got.b, mon_got.func, mon_got.alusrc, mon_got.rd, mon_got.ill,
                             mon_exp.a, mon_exp.b, mon_exp.func, mon_exp.alusrc, mon_exp.rd, mon_exp.ill);
                end
            end
        end
    end

    // Present an instruction (called just after a rising edge) and wait for its accept
    task automatic send(input logic [31:0] instr, input exp_t e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_instr = instr;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_run++;
            n_fail++;
            $display("FAIL send_timeout: in_ready got %b expected 1", in_ready);
        end else begin
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        @(posedge clk);
        #1;
        wb_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        flush     = 1'b0;
        out_ready = 1'b1;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;

        // Reset state
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_out_misc", {19'd0, out_func, out_alusrc, out_rd, out_illegal}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd3);

        // Back-to-back decode of every supported form plus illegal encodings
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, mk(32'd5, 32'd3, 6'h20, 1'b1, 5'd3, 1'b0));
        send({6'h08, 5'd1, 5'd4, 16'hFFFF},          mk(32'd5, 32'hFFFF_FFFF, 6'h20, 1'b1, 5'd4, 1'b0));
        send({6'h00, 5'd0, 5'd2, 5'd7, 5'd4, 6'h00}, mk(32'd3, 32'd4, 6'h00, 1'b1, 5'd7, 1'b0));
        send({6'h23, 5'd1, 5'd2, 16'h1234},          mk(32'd0, 32'd0, 6'h34, 1'b0, 5'd0, 1'b1));
        send({6'h00, 5'd0, 5'd1, 5'd5, 5'd31, 6'h02}, mk(32'd5, 32'd31, 6'h02, 1'b1, 5'd5, 1'b0));
        send({6'h00, 5'd2, 5'd1, 5'd6, 5'd0, 6'h22}, mk(32'd3, 32'd5, 6'h22, 1'b1, 5'd6, 1'b0));
        send({6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h25}, mk(32'd5, 32'd3, 6'h25, 1'b1, 5'd8, 1'b0));
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2A}, mk(32'd0, 32'd0, 6'h2A, 1'b0, 5'd0, 1'b1));
        send({6'h08, 5'd2, 5'd9, 16'h7FFF},          mk(32'd3, 32'h0000_7FFF, 6'h20, 1'b1, 5'd9, 1'b0));
        idle(2);

        // Backpressure: held entry stays stable and the next instruction waits
        out_ready = 1'b0;
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h24}, mk(32'd5, 32'd3, 6'h24, 1'b1, 5'd3, 1'b0));
        in_valid = 1'b1;
        in_instr = {6'h08, 5'd2, 5'd9, 16'h0010};
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
            chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_out_a", out_a, 32'd5);
            chk("stall_out_b", out_b, 32'd3);
            chk("stall_out_misc", {20'd0, out_func, out_rd, out_illegal}, {20'd0, 6'h24, 5'd3, 1'b0});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send({6'h08, 5'd2, 5'd9, 16'h0010}, mk(32'd3, 32'd16, 6'h20, 1'b1, 5'd9, 1'b0));
        idle(2);

        // Writeback to R1 in the same cycle as an accept that reads R1
        wb_en   = 1'b1;
        wb_addr = 5'd1;
        wb_data = 32'd9;
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, mk(BYP_A, 32'd3, 6'h20, 1'b1, 5'd3, 1'b0));
        wb_en = 1'b0;
        send({6'h00, 5'd1, 5'd1, 5'd10, 5'd0, 6'h20}, mk(32'd9, 32'd9, 6'h20, 1'b1, 5'd10, 1'b0));

        // Writes to R0 are discarded
        wb(5'd0, 32'hDEAD_BEEF);
        send({6'h00, 5'd0, 5'd0, 5'd11, 5'd0, 6'h25}, mk(32'd0, 32'd0, 6'h25, 1'b1, 5'd11, 1'b0));
        idle(2);

        // Flush of a held entry
        out_ready = 1'b0;
        send({6'h00, 5'd1, 5'd2, 5'd12, 5'd0, 6'h20}, mk(32'd9, 32'd3, 6'h20, 1'b1, 5'd12, 1'b0));
        @(negedge clk);
        chk("flush_pre_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        if (sb.size() > 0) void'(sb.pop_back());
        @(negedge clk);
        chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Asynchronous reset while an entry is held
        send({6'h00, 5'd1, 5'd2, 5'd13, 5'd0, 6'h22}, mk(32'd9, 32'd3, 6'h22, 1'b1, 5'd13, 1'b0));
        @(negedge clk);
        chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_out_a", out_a, 32'd0);
        chk("arst_out_b", out_b, 32'd0);
        chk("arst_out_misc", {19'd0, out_func, out_alusrc, out_rd, out_illegal}, 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;

        // Register file was cleared by the reset
        send({6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20}, mk(32'd0, 32'd0, 6'h20, 1'b1, 5'd3, 1'b0));
        idle(3);
        chk("sb_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
